// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc: single-wire NeoPixel bit encoder.
// Each accepted bit drives a high phase then a low phase. The phase lengths
// are chosen by the bit value from runtime count inputs. bit_done_out pulses
// in the final low cycle, so the next bit can follow with no idle gap.
// Optional build macro: WS2812_BIT_ENC_INV_EN inverts the line output
// (idle/reset level 1) for inverting level shifters.
module ws2812_bit_enc #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             bit_rdy_in,
  input  logic             bit_data_in,
  input  logic [CNT_W-1:0] t0h_cnt_in,
  input  logic [CNT_W-1:0] t0l_cnt_in,
  input  logic [CNT_W-1:0] t1h_cnt_in,
  input  logic [CNT_W-1:0] t1l_cnt_in,
  output logic             bit_done_out,
  output logic             bit_busy_out,
  output logic             bit_code_out
);

`ifdef WS2812_BIT_ENC_INV_EN
  localparam logic LINE_INV = 1'b1;
`else
  localparam logic LINE_INV = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_tl;
  logic [CNT_W-1:0] w_tl_nxt;
  logic [CNT_W-1:0] w_sel_th;
  logic [CNT_W-1:0] w_sel_tl;
  logic             w_done_nxt;
  logic             w_busy_nxt;
  logic             w_code_nxt;

  // A zero length is stretched to one cycle so that no phase is ever skipped
  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // Phase lengths for the bit being offered on this cycle
  always_comb begin
    w_sel_th = bit_data_in ? t1h_cnt_in : t0h_cnt_in;
    w_sel_tl = bit_data_in ? t1l_cnt_in : t0l_cnt_in;
  end

  // Next-state, counter and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tl_nxt    = r_tl;
    case (r_state)
      S_IDLE: begin
        if (bit_rdy_in) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = clamp1(w_sel_th);
          w_tl_nxt    = clamp1(w_sel_tl);
        end
      end
      S_HIGH: begin
        if (r_cnt == ONE) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = r_tl;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      S_LOW: begin
        if (r_cnt == ONE) begin
          if (bit_rdy_in) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = clamp1(w_sel_th);
            w_tl_nxt    = clamp1(w_sel_tl);
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they land in registers
    // aligned with the state they describe.
    w_done_nxt = (w_state_nxt == S_LOW) && (w_cnt_nxt == ONE);
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_code_nxt = (w_state_nxt == S_HIGH) ^ LINE_INV;
  end

  // State, counter, latched low length and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tl         <= '0;
      bit_done_out <= 1'b0;
      bit_busy_out <= 1'b0;
      bit_code_out <= LINE_INV;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tl         <= w_tl_nxt;
      bit_done_out <= w_done_nxt;
      bit_busy_out <= w_busy_nxt;
      bit_code_out <= w_code_nxt;
    end
  end

endmodule

// File: tb/tb_ws2812_bit_enc.sv
// Testbench for ws2812_bit_enc. A behavioural model tracks each accepted bit
// as (start offset k, TH, TL) and derives the line, busy and done levels
// arithmetically. Directed cases pin the model with literal expectations.
module tb_ws2812_bit_enc;

`ifdef WS2812_BIT_ENC_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rdy = 1'b0;
  logic       data = 1'b0;
  logic [7:0] t0h = 8'd20;
  logic [7:0] t0l = 8'd43;
  logic [7:0] t1h = 8'd40;
  logic [7:0] t1l = 8'd23;
  logic       done;
  logic       busy;
  logic       code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ws2812_bit_enc #(.CNT_W(8)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .bit_rdy_in   (rdy),
    .bit_data_in  (data),
    .t0h_cnt_in   (t0h),
    .t0l_cnt_in   (t0l),
    .t1h_cnt_in   (t1h),
    .t1l_cnt_in   (t1l),
    .bit_done_out (done),
    .bit_busy_out (busy),
    .bit_code_out (code)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Behavioural model: m_k counts cycles since the accepting edge
  bit m_act = 1'b0;
  int m_k   = 0;
  int m_th  = 0;
  int m_tl  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_k   <= 0;
      m_th  <= 0;
      m_tl  <= 0;
    end else if (rdy && (!m_act || (m_k == m_th + m_tl - 1))) begin
      m_act <= 1'b1;
      m_k   <= 0;
      m_th  <= clamp(data ? int'(t1h) : int'(t0h));
      m_tl  <= clamp(data ? int'(t1l) : int'(t0l));
    end else if (m_act) begin
      if (m_k + 1 == m_th + m_tl) m_act <= 1'b0;
      m_k <= m_k + 1;
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_act));
    check("code", int'(code), int'((m_act && (m_k < m_th)) ^ INV));
    check("done", int'(done), int'(m_act && (m_k == m_th + m_tl - 1)));
  end

  // Send one bit and measure its waveform; optionally change t1h or
  // strobe bit_rdy_in at a given cycle offset while the bit is in flight.
  task automatic measure(input bit d, input int chg_at, input logic [7:0] chg_val,
                         input int strobe_at, output int hi, output int lo,
                         output int done_at, output int busy_n, output int done_n);
    hi = 0; lo = 0; done_at = -1; busy_n = 0; done_n = 0;
    @(negedge clk);
    rdy = 1'b1;
    data = d;
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0 && !busy) break;
      if ((code ^ INV) == 1'b1) hi++;
      else if (busy) lo++;
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        done_n++;
      end
      if (i == chg_at) t1h = chg_val;
      rdy = (i == strobe_at);
      data = 1'($urandom);
      @(negedge clk);
    end
    rdy = 1'b0;
  endtask

  int hi, lo, dat, bn, dn;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_code", int'(code), int'(INV));
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_code", int'(code), int'(INV));

    // Single 0 bit
    measure(1'b0, -1, 8'd0, -1, hi, lo, dat, bn, dn);
    check("b0_hi", hi, 20);
    check("b0_lo", lo, 43);
    check("b0_done_at", dat, 62);
    check("b0_busy", bn, 63);
    check("b0_ndone", dn, 1);

    // Single 1 bit
    measure(1'b1, -1, 8'd0, -1, hi, lo, dat, bn, dn);
    check("b1_hi", hi, 40);
    check("b1_lo", lo, 23);
    check("b1_done_at", dat, 62);

    // Back-to-back 1,0,1 with no idle cycles
    begin
      int idx, busy_cnt, hi_cnt, dones;
      bit seq[2];
      seq[0] = 1'b0;
      seq[1] = 1'b1;
      idx = 0; busy_cnt = 0; hi_cnt = 0; dones = 0;
      @(negedge clk);
      rdy = 1'b1;
      data = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if (i > 0 && !busy) break;
        if (busy) busy_cnt++;
        if ((code ^ INV) == 1'b1) hi_cnt++;
        if (done) dones++;
        if (done && idx < 2) begin
          rdy = 1'b1;
          data = seq[idx];
          idx++;
        end else begin
          rdy = 1'b0;
        end
        @(negedge clk);
      end
      rdy = 1'b0;
      check("b2b_busy", busy_cnt, 189);
      check("b2b_hi", hi_cnt, 100);
      check("b2b_dones", dones, 3);
    end

    // t1h changed mid-HIGH: current bit keeps 40, next uses 10
    measure(1'b1, 5, 8'd10, -1, hi, lo, dat, bn, dn);
    check("chg_cur_hi", hi, 40);
    check("chg_cur_done_at", dat, 62);
    measure(1'b1, -1, 8'd0, -1, hi, lo, dat, bn, dn);
    check("chg_next_hi", hi, 10);
    check("chg_next_done_at", dat, 32);
    t1h = 8'd40;

    // Zero high length clamps to one
    t0h = 8'd0;
    t0l = 8'd1;
    measure(1'b0, -1, 8'd0, -1, hi, lo, dat, bn, dn);
    check("zero_hi", hi, 1);
    check("zero_lo", lo, 1);
    check("zero_done_at", dat, 1);
    check("zero_busy", bn, 2);
    t0h = 8'd20;
    t0l = 8'd43;

    // Strobe mid-HIGH is ignored
    measure(1'b0, -1, 8'd0, 5, hi, lo, dat, bn, dn);
    check("strobe_ndone", dn, 1);
    check("strobe_busy", bn, 63);

    // Reset mid-LOW
    @(negedge clk);
    rdy = 1'b1;
    data = 1'b0;
    @(negedge clk);
    rdy = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_code", int'(code), int'(INV));
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("arst_nodone", dn, 0);
    measure(1'b1, -1, 8'd0, -1, hi, lo, dat, bn, dn);
    check("post_rst_hi", hi, 40);
    check("post_rst_done_at", dat, 62);

    // Randomized traffic, timings and occasional async resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 3) == 0);
      data = 1'($urandom);
      if ($urandom_range(0, 15) == 0) t0h = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) t0l = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) t1h = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) t1l = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    rdy = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
